mem_access_unit: RTL and testbench

- Parametrised successor to the pipeline memory stage's bus access logic.
- Accepts one load or store per transaction from the execute/memory boundary and drives the data bus through a registered request FSM.
- Holds each request stable until `data_ok`, and formats load data (byte-lane select, sign/zero extension) for XLEN 32 or 64.
- Adds what the earlier stage lacks: misalignment/illegal-size detection, and flush handling that drains an in-flight bus request without writeback.

---
 rtl/mem_access_unit_pkg.sv | 31 +++
 rtl/mem_lane.sv | 54 +++++
 rtl/mem_access_unit.sv | 178 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared memory-access types: bus transfer sizes, memory op codes and funct3 decode.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    MemNone  = 2'd0,
    MemLoad  = 2'd1,
    MemStore = 2'd2
  } mem_op_t;

  // ldu-style encoding with the unsigned bit set on a doubleword: no such instruction.
  localparam logic [2:0] MEM_FUNCT3_ILLEGAL = 3'b111;

  function automatic msize_t funct3_to_msize(input logic [2:0] funct3);
    msize_t size;
    unique case (funct3[1:0])
      2'b00:   size = MSIZE1;
      2'b01:   size = MSIZE2;
      2'b10:   size = MSIZE4;
      default: size = MSIZE8;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane formatting between the pipeline and the data bus: store shift/strobe and
// load lane extract with sign or zero extension.
module mem_lane
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  localparam int unsigned NBYTE = XLEN / 8,
  localparam int unsigned AW    = $clog2(NBYTE)
) (
  input  logic [AW-1:0]    st_addr_low_i,
  input  msize_t           st_size_i,
  input  logic [XLEN-1:0]  st_wdata_i,
  output logic [XLEN-1:0]  st_data_o,
  output logic [NBYTE-1:0] st_strobe_o,
  input  logic [AW-1:0]    ld_addr_low_i,
  input  msize_t           ld_size_i,
  input  logic             ld_unsigned_i,
  input  logic [XLEN-1:0]  ld_rdata_i,
  output logic [XLEN-1:0]  ld_data_o
);

  int unsigned     st_nbytes;
  int unsigned     ld_nbytes;
  logic [NBYTE-1:0] st_mask;
  logic [XLEN-1:0]  ld_shifted;
  logic [XLEN-1:0]  ld_keep;
  logic [XLEN-1:0]  ld_top;
  logic             ld_ext;

  always_comb begin
    st_nbytes = 32'd1 << st_size_i;
    st_mask   = '0;
    for (int i = 0; i < int'(NBYTE); i++) begin
      st_mask[i] = (i < int'(st_nbytes));
    end
    st_strobe_o = st_mask << st_addr_low_i;
    st_data_o   = st_wdata_i << {st_addr_low_i, 3'b000};
  end

  // ld_keep covers the bytes of the access; ld_top marks its most significant bit.
  always_comb begin
    ld_nbytes  = 32'd1 << ld_size_i;
    ld_shifted = ld_rdata_i >> {ld_addr_low_i, 3'b000};
    ld_keep    = '0;
    ld_top     = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      ld_keep[i] = (i < int'(8 * ld_nbytes));
      ld_top[i]  = (i == int'(8 * ld_nbytes) - 1);
    end
    ld_ext    = !ld_unsigned_i && |(ld_shifted & ld_top);
    ld_data_o = (ld_shifted & ld_keep) | (ld_ext ? ~ld_keep : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage bus access unit: accepts one load/store, holds a registered bus request until
// data_ok, formats the load result and reports misaligned or illegal-size accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  localparam int unsigned NBYTE = XLEN / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic [2:0]       in_funct3_i,
  input  logic [XLEN-1:0]  in_addr_i,
  input  logic [XLEN-1:0]  in_wdata_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  output logic [XLEN-1:0]  out_rdata_o,
  output logic             out_misalign_o,
  output logic             busy_o,
  output logic             dreq_valid_o,
  output logic [XLEN-1:0]  dreq_addr_o,
  output logic [2:0]       dreq_size_o,
  output logic [NBYTE-1:0] dreq_strobe_o,
  output logic [XLEN-1:0]  dreq_data_o,
  input  logic             dresp_data_ok_i,
  input  logic [XLEN-1:0]  dresp_data_i
);

  localparam int unsigned AW = $clog2(NBYTE);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain, StExc} state_e;

  state_e           state_q, state_d;
  mem_op_t          op;
  msize_t           req_size;
  logic             illegal, misalign, accept, take_exc, is_store;
  logic [XLEN-1:0]  st_data, ld_data;
  logic [NBYTE-1:0] st_strobe;

  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [NBYTE-1:0] strobe_q, strobe_d;
  msize_t           size_q, size_d;
  logic             unsigned_q, unsigned_d;
  logic             store_q, store_d;

  assign op       = mem_op_t'(in_op_i);
  assign is_store = (op == MemStore);
  assign req_size = funct3_to_msize(in_funct3_i);
  assign illegal  = (in_funct3_i == MEM_FUNCT3_ILLEGAL) ||
                    ((XLEN == 32) && (in_funct3_i[1:0] == 2'b11));

  always_comb begin
    misalign = 1'b0;
    case (req_size)
      MSIZE2:  misalign = in_addr_i[0];
      MSIZE4:  misalign = |in_addr_i[1:0];
      MSIZE8:  misalign = |in_addr_i[2:0];
      default: misalign = 1'b0;
    endcase
  end

  assign accept   = in_valid_i && (state_q == StIdle) && (op != MemNone) && !flush_i;
  assign take_exc = illegal || misalign;

  mem_lane #(
    .XLEN(XLEN)
  ) u_lane (
    .st_addr_low_i (in_addr_i[AW-1:0]),
    .st_size_i     (req_size),
    .st_wdata_i    (in_wdata_i),
    .st_data_o     (st_data),
    .st_strobe_o   (st_strobe),
    .ld_addr_low_i (addr_q[AW-1:0]),
    .ld_size_i     (size_q),
    .ld_unsigned_i (unsigned_q),
    .ld_rdata_i    (dresp_data_i),
    .ld_data_o     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = take_exc ? StExc : StBusy;
      StBusy: begin
        if (dresp_data_ok_i)  state_d = StIdle;
        else if (flush_i)     state_d = StDrain;
      end
      // The bus cannot abort, so a drained request still waits for its data_ok.
      StDrain: if (dresp_data_ok_i) state_d = StIdle;
      StExc:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_o     = (state_q == StIdle);
    busy_o         = (state_q != StIdle);
    dreq_valid_o   = (state_q == StBusy) || (state_q == StDrain);
    out_valid_o    = 1'b0;
    out_misalign_o = 1'b0;
    out_rdata_o    = '0;
    unique case (state_q)
      StBusy: begin
        if (dresp_data_ok_i && !flush_i) begin
          out_valid_o = 1'b1;
          out_rdata_o = store_q ? '0 : ld_data;
        end
      end
      StExc: begin
        if (!flush_i) begin
          out_valid_o    = 1'b1;
          out_misalign_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    store_d    = store_q;
    wdata_d    = wdata_q;
    strobe_d   = strobe_q;
    if (accept && !take_exc) begin
      addr_d     = in_addr_i;
      size_d     = req_size;
      unsigned_d = in_funct3_i[2];
      store_d    = is_store;
      wdata_d    = is_store ? st_data : '0;
      strobe_d   = is_store ? st_strobe : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      size_q     <= MSIZE1;
      unsigned_q <= 1'b0;
      store_q    <= 1'b0;
      wdata_q    <= '0;
      strobe_q   <= '0;
    end else begin
      addr_q     <= addr_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      store_q    <= store_d;
      wdata_q    <= wdata_d;
      strobe_q   <= strobe_d;
    end
  end

  assign dreq_addr_o   = addr_q;
  assign dreq_size_o   = size_q;
  assign dreq_strobe_o = strobe_q;
  assign dreq_data_o   = wdata_q;

  a_dreq_stable: assert property (@(posedge clk) disable iff (reset)
    (dreq_valid_o && !dresp_data_ok_i) |=>
      ($stable(dreq_addr_o) && $stable(dreq_size_o) &&
       $stable(dreq_strobe_o) && $stable(dreq_data_o)));

  a_no_valid_in_drain: assert property (@(posedge clk) disable iff (reset)
    (state_q == StDrain) |-> !out_valid_o);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: XLEN=64 instance for the main flows, XLEN=32 instance
// for the width-dependent size decode and lane formatting.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        in_valid, flush, data_ok, in_ready, out_valid, out_misalign, busy, dreq_valid;
  logic [1:0]  in_op;
  logic [2:0]  in_funct3, dreq_size;
  logic [63:0] in_addr, in_wdata, dresp_data, out_rdata, dreq_addr, dreq_data;
  logic [7:0]  dreq_strobe;

  logic        in_valid_s, flush_s, data_ok_s, in_ready_s, out_valid_s, out_misalign_s, busy_s;
  logic        dreq_valid_s;
  logic [1:0]  in_op_s;
  logic [2:0]  in_funct3_s, dreq_size_s;
  logic [31:0] in_addr_s, in_wdata_s, dresp_data_s, out_rdata_s, dreq_addr_s, dreq_data_s;
  logic [3:0]  dreq_strobe_s;

  mem_access_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op), .in_funct3_i(in_funct3),
    .in_addr_i(in_addr), .in_wdata_i(in_wdata), .flush_i(flush),
    .out_valid_o(out_valid), .out_rdata_o(out_rdata), .out_misalign_o(out_misalign),
    .busy_o(busy), .dreq_valid_o(dreq_valid), .dreq_addr_o(dreq_addr), .dreq_size_o(dreq_size),
    .dreq_strobe_o(dreq_strobe), .dreq_data_o(dreq_data),
    .dresp_data_ok_i(data_ok), .dresp_data_i(dresp_data)
  );

  mem_access_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid_s), .in_ready_o(in_ready_s), .in_op_i(in_op_s),
    .in_funct3_i(in_funct3_s), .in_addr_i(in_addr_s), .in_wdata_i(in_wdata_s),
    .flush_i(flush_s), .out_valid_o(out_valid_s), .out_rdata_o(out_rdata_s),
    .out_misalign_o(out_misalign_s), .busy_o(busy_s), .dreq_valid_o(dreq_valid_s),
    .dreq_addr_o(dreq_addr_s), .dreq_size_o(dreq_size_s), .dreq_strobe_o(dreq_strobe_s),
    .dreq_data_o(dreq_data_s), .dresp_data_ok_i(data_ok_s), .dresp_data_i(dresp_data_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] w);
    in_valid = 1'b1; in_op = op; in_funct3 = f3; in_addr = a; in_wdata = w;
    tick();
    in_valid = 1'b0; in_op = 2'd0;
  endtask

  task automatic issue32(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] w);
    in_valid_s = 1'b1; in_op_s = op; in_funct3_s = f3; in_addr_s = a; in_wdata_s = w;
    tick();
    in_valid_s = 1'b0; in_op_s = 2'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || dreq_valid !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl: rdy=%b busy=%b dreq=%b ov=%b need 1 0 0 0",
                               in_ready, busy, dreq_valid, out_valid); end
    checks++;
    if (out_rdata !== 64'h0 || dreq_addr !== 64'h0 || dreq_strobe !== 8'h0 ||
        dreq_data !== 64'h0 || dreq_size !== 3'd0 || out_misalign !== 1'b0)
      begin errors++; $display("FAIL reset_data: rdata=%h addr=%h strb=%h data=%h size=%0d",
                               out_rdata, dreq_addr, dreq_strobe, dreq_data, dreq_size); end
    checks++;
    if (in_ready_s !== 1'b1 || dreq_valid_s !== 1'b0 || out_valid_s !== 1'b0)
      begin errors++; $display("FAIL reset32: rdy=%b dreq=%b ov=%b need 1 0 0",
                               in_ready_s, dreq_valid_s, out_valid_s); end
  endtask

  task automatic test_load_byte();
    for (int u = 0; u < 2; u++) begin
      logic [63:0] exp_r;
      exp_r = (u == 1) ? 64'h80 : 64'hFFFF_FFFF_FFFF_FF80;
      issue(2'd1, (u == 1) ? 3'b100 : 3'b000, 64'h8000_0003, 64'h0);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (dreq_valid !== 1'b1 || dreq_addr !== 64'h8000_0003 || dreq_size !== 3'd0 ||
            dreq_strobe !== 8'h0 || out_valid !== 1'b0)
          begin errors++; $display("FAIL lb_hold%0d: v=%b addr=%h size=%0d strb=%h ov=%b", c,
                                   dreq_valid, dreq_addr, dreq_size, dreq_strobe, out_valid); end
        tick();
      end
      data_ok = 1'b1; dresp_data = 64'h0000_0000_8000_0000;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_misalign !== 1'b0 || out_rdata !== exp_r)
        begin errors++; $display("FAIL lb_result%0d: ov=%b mis=%b rdata=%h need 1 0 %h", u,
                                 out_valid, out_misalign, out_rdata, exp_r); end
      tick();
      data_ok = 1'b0; dresp_data = 64'h0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin errors++; $display("FAIL lb_done%0d: ov=%b rdy=%b need 0 1", u, out_valid,
                                 in_ready); end
    end
  endtask

  task automatic test_store_half();
    issue(2'd2, 3'b001, 64'h1006, 64'hABCD);
    checks++;
    if (dreq_valid !== 1'b1 || dreq_strobe !== 8'b1100_0000 || dreq_size !== 3'd1 ||
        dreq_data !== 64'hABCD_0000_0000_0000 || dreq_addr !== 64'h1006)
      begin errors++; $display("FAIL sh_req: v=%b strb=%b size=%0d data=%h addr=%h", dreq_valid,
                               dreq_strobe, dreq_size, dreq_data, dreq_addr); end
    data_ok = 1'b1; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_rdata !== 64'h0 || out_misalign !== 1'b0)
      begin errors++; $display("FAIL sh_done: ov=%b rdata=%h mis=%b need 1 0 0", out_valid,
                               out_rdata, out_misalign); end
    tick();
    data_ok = 1'b0; dresp_data = 64'h0;
  endtask

  task automatic test_misalign();
    in_valid = 1'b1; in_op = 2'd1; in_funct3 = 3'b010; in_addr = 64'h1002;
    #1;
    checks++;
    if (dreq_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL mis_pre: dreq=%b rdy=%b need 0 1", dreq_valid, in_ready); end
    tick();
    in_valid = 1'b0; in_op = 2'd0;
    checks++;
    if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_rdata !== 64'h0 || dreq_valid !== 1'b0)
      begin errors++; $display("FAIL mis_exc: ov=%b mis=%b rdata=%h dreq=%b need 1 1 0 0",
                               out_valid, out_misalign, out_rdata, dreq_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dreq_valid !== 1'b0)
      begin errors++; $display("FAIL mis_after: ov=%b rdy=%b dreq=%b need 0 1 0", out_valid,
                               in_ready, dreq_valid); end
  endtask

  task automatic test_width_decode();
    issue32(2'd1, 3'b011, 32'h1000, 32'h0);
    checks++;
    if (out_valid_s !== 1'b1 || out_misalign_s !== 1'b1 || dreq_valid_s !== 1'b0)
      begin errors++; $display("FAIL ld32_illegal: ov=%b mis=%b dreq=%b need 1 1 0", out_valid_s,
                               out_misalign_s, dreq_valid_s); end
    tick();
    checks++;
    if (in_ready_s !== 1'b1 || dreq_valid_s !== 1'b0 || out_valid_s !== 1'b0)
      begin errors++; $display("FAIL ld32_after: rdy=%b dreq=%b ov=%b need 1 0 0", in_ready_s,
                               dreq_valid_s, out_valid_s); end
    issue(2'd1, 3'b011, 64'h1000, 64'h0);
    checks++;
    if (dreq_valid !== 1'b1 || dreq_size !== 3'd3)
      begin errors++; $display("FAIL ld64_req: dreq=%b size=%0d need 1 3", dreq_valid,
                               dreq_size); end
    data_ok = 1'b1; dresp_data = 64'h1122_3344_5566_7788;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_misalign !== 1'b0 || out_rdata !== 64'h1122_3344_5566_7788)
      begin errors++; $display("FAIL ld64_result: ov=%b mis=%b rdata=%h", out_valid,
                               out_misalign, out_rdata); end
    tick();
    data_ok = 1'b0;
    // XLEN=32 lanes: signed halfword from the upper half, then a byte store to lane 3.
    issue32(2'd1, 3'b001, 32'h2, 32'h0);
    data_ok_s = 1'b1; dresp_data_s = 32'h8001_0000;
    #1;
    checks++;
    if (out_valid_s !== 1'b1 || out_rdata_s !== 32'hFFFF_8001 || dreq_size_s !== 3'd1)
      begin errors++; $display("FAIL lh32: ov=%b rdata=%h size=%0d need 1 ffff8001 1",
                               out_valid_s, out_rdata_s, dreq_size_s); end
    tick();
    data_ok_s = 1'b0;
    issue32(2'd2, 3'b000, 32'h3, 32'h5A);
    checks++;
    if (dreq_strobe_s !== 4'b1000 || dreq_data_s !== 32'h5A00_0000)
      begin errors++; $display("FAIL sb32: strb=%b data=%h need 1000 5a000000", dreq_strobe_s,
                               dreq_data_s); end
    data_ok_s = 1'b1;
    #1;
    checks++;
    if (out_valid_s !== 1'b1 || out_rdata_s !== 32'h0)
      begin errors++; $display("FAIL sb32_done: ov=%b rdata=%h need 1 0", out_valid_s,
                               out_rdata_s); end
    tick();
    data_ok_s = 1'b0; dresp_data_s = 32'h0;
  endtask

  task automatic test_flush_drain();
    issue(2'd1, 3'b010, 64'h2000, 64'h0);
    flush = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dreq_valid !== 1'b1)
      begin errors++; $display("FAIL fl_busy: ov=%b dreq=%b need 0 1", out_valid, dreq_valid); end
    tick();
    flush = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (dreq_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0)
        begin errors++; $display("FAIL fl_drain%0d: dreq=%b rdy=%b busy=%b ov=%b need 1 0 1 0",
                                 k, dreq_valid, in_ready, busy, out_valid); end
      if (k == 2) flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dreq_valid !== 1'b1)
      begin errors++; $display("FAIL fl_ack: ov=%b dreq=%b need 0 1", out_valid, dreq_valid); end
    tick();
    data_ok = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || dreq_valid !== 1'b0)
      begin errors++; $display("FAIL fl_idle: rdy=%b dreq=%b need 1 0", in_ready, dreq_valid); end
    issue(2'd1, 3'b011, 64'h2008, 64'h0);
    data_ok = 1'b1; dresp_data = 64'h0123_4567_89AB_CDEF;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_rdata !== 64'h0123_4567_89AB_CDEF)
      begin errors++; $display("FAIL fl_next: ov=%b rdata=%h", out_valid, out_rdata); end
    tick();
    data_ok = 1'b0;
    // Flush coinciding with data_ok: the response is consumed silently.
    issue(2'd1, 3'b000, 64'h2001, 64'h0);
    flush = 1'b1; data_ok = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0)
      begin errors++; $display("FAIL fl_same: ov=%b need 0", out_valid); end
    tick();
    flush = 1'b0; data_ok = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || dreq_valid !== 1'b0)
      begin errors++; $display("FAIL fl_same_idle: rdy=%b dreq=%b need 1 0", in_ready,
                               dreq_valid); end
  endtask

  task automatic test_idle_cases();
    in_valid = 1'b1; in_op = 2'd0; in_funct3 = 3'b010; in_addr = 64'h3000;
    tick();
    checks++;
    if (in_ready !== 1'b1 || dreq_valid !== 1'b0)
      begin errors++; $display("FAIL op_none: rdy=%b dreq=%b need 1 0", in_ready, dreq_valid); end
    in_op = 2'd1; flush = 1'b1;
    tick();
    in_valid = 1'b0; in_op = 2'd0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || dreq_valid !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL idle_flush: rdy=%b dreq=%b ov=%b need 1 0 0", in_ready,
                               dreq_valid, out_valid); end
    issue(2'd1, 3'b001, 64'h3001, 64'h0);
    flush = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_misalign !== 1'b0)
      begin errors++; $display("FAIL exc_flush: ov=%b mis=%b need 0 0", out_valid,
                               out_misalign); end
    tick();
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL exc_flush_idle: rdy=%b ov=%b need 1 0", in_ready,
                               out_valid); end
  endtask

  task automatic test_reset_busy();
    issue(2'd1, 3'b011, 64'h4000, 64'h0);
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (dreq_valid !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL rst_busy: dreq=%b rdy=%b ov=%b need 0 1 0", dreq_valid,
                               in_ready, out_valid); end
    reset = 1'b0;
    data_ok = 1'b1; dresp_data = 64'h5555_5555_5555_5555;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_rdata !== 64'h0)
      begin errors++; $display("FAIL rst_late_ack: ov=%b rdata=%h need 0 0", out_valid,
                               out_rdata); end
    tick();
    data_ok = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || dreq_valid !== 1'b0)
      begin errors++; $display("FAIL rst_after: rdy=%b dreq=%b need 1 0", in_ready,
                               dreq_valid); end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_op = 2'd0; in_funct3 = 3'd0; in_addr = '0; in_wdata = '0;
    flush = 1'b0; data_ok = 1'b0; dresp_data = '0;
    in_valid_s = 1'b0; in_op_s = 2'd0; in_funct3_s = 3'd0; in_addr_s = '0; in_wdata_s = '0;
    flush_s = 1'b0; data_ok_s = 1'b0; dresp_data_s = '0;
    test_reset();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_width_decode();
    test_flush_drain();
    test_idle_cases();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
